// File: rtl/lcd_write_arbiter.sv
// Arbiter between LCD word sources and the single write engine.
// Grants one channel, strobes its word, waits for wr_done, then acks.
module lcd_write_arbiter #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 9,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 50000
) (
    input  logic                     sys_clk_50MHz,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_lock,
    input  logic                     wr_done,
    output logic [DATA_W-1:0]        data,
    output logic                     en_write,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        grant,
    output logic                     err_timeout
);

    localparam int PW = $clog2(NUM_CH);
    localparam logic [15:0] TO_LAST =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);
    localparam logic [PW:0] NCH = (PW+1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t              state, state_n;
    logic [15:0]         timer, timer_n;
    logic [PW-1:0]       rr_ptr, rr_ptr_n;
    logic [PW-1:0]       gidx, gidx_n;
    logic [DATA_W-1:0]   data_n;
    logic                en_n, err_n;
    logic [NUM_CH-1:0]   ack_n, grant_n;
    logic [PW-1:0]       win;
    logic                win_ok;
    logic [PW:0]         idx;
    logic [DATA_W-1:0]   words [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_words
        assign words[i] = ch_data[i*DATA_W +: DATA_W];
    end

    // Round robin scans upward from the channel after the last winner.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        idx    = '0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = {1'b0, rr_ptr} + (PW+1)'(i + 1);
                if (idx >= NCH)
                    idx = idx - NCH;
                if (!win_ok && ch_req[idx[PW-1:0]]) begin
                    win    = idx[PW-1:0];
                    win_ok = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_req[i]) begin
                    win    = PW'(i);
                    win_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        rr_ptr_n = rr_ptr;
        gidx_n   = gidx;
        data_n   = data;
        grant_n  = grant;
        en_n     = 1'b0;
        ack_n    = '0;
        err_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_ok) begin
                    gidx_n  = win;
                    grant_n = ONE << win;
                    data_n  = words[win];
                    en_n    = 1'b1;
                    timer_n = '0;
                    state_n = WAIT;
                    if (ARB_MODE == 1)
                        rr_ptr_n = win;
                end
            end
            WAIT: begin
                timer_n = timer + 16'd1;
                // A completion in the expiry cycle still counts as success.
                if (wr_done) begin
                    ack_n   = grant;
                    state_n = ACK;
                end else if (TIMEOUT != 0 && timer == TO_LAST) begin
                    err_n   = 1'b1;
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            ACK: state_n = HOLD;
            HOLD: begin
                if (!ch_lock[gidx]) begin
                    grant_n = '0;
                    state_n = IDLE;
                end else if (ch_req[gidx]) begin
                    data_n  = words[gidx];
                    en_n    = 1'b1;
                    timer_n = '0;
                    state_n = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            rr_ptr      <= LAST_CH;
            gidx        <= '0;
            data        <= '0;
            en_write    <= 1'b0;
            ch_ack      <= '0;
            grant       <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            rr_ptr      <= rr_ptr_n;
            gidx        <= gidx_n;
            data        <= data_n;
            en_write    <= en_n;
            ch_ack      <= ack_n;
            grant       <= grant_n;
            err_timeout <= err_n;
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: fixed-priority and
// round-robin instances share stimulus, outputs checked separately.
module tb_lcd_write_arbiter;

    localparam logic [8:0] CH0 = 9'h101;
    localparam logic [8:0] CH1 = 9'h022;
    localparam logic [8:0] CH2 = 9'h1F3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  lock = '0;
    logic [26:0] cdata = {CH2, CH1, CH0};
    logic        done = 1'b0;

    logic [8:0] fp_data, rr_data;
    logic       fp_en, rr_en, fp_err, rr_err;
    logic [2:0] fp_ack, rr_ack, fp_grant, rr_grant;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_write_arbiter #(
        .NUM_CH(3), .DATA_W(9), .ARB_MODE(0), .TIMEOUT(10)
    ) u_fp (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n),
        .ch_req(req), .ch_data(cdata), .ch_lock(lock),
        .wr_done(done), .data(fp_data), .en_write(fp_en),
        .ch_ack(fp_ack), .grant(fp_grant), .err_timeout(fp_err)
    );

    lcd_write_arbiter #(
        .NUM_CH(3), .DATA_W(9), .ARB_MODE(1), .TIMEOUT(10)
    ) u_rr (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n),
        .ch_req(req), .ch_data(cdata), .ch_lock(lock),
        .wr_done(done), .data(rr_data), .en_write(rr_en),
        .ch_ack(rr_ack), .grant(rr_grant), .err_timeout(rr_err)
    );

    typedef struct {
        logic [2:0] req;
        logic       done;
        logic [2:0] g;
        logic       en;
        logic [2:0] ack;
        logic       err;
        logic [8:0] d;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        done  = 1'b0;
        cdata = {CH2, CH1, CH0};
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic wait_en(input bit rr, input string nm, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rr ? rr_en : fp_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL %s: no en_write within 40 cycles", nm);
        end
    endtask

    // Engine model: wr_done sampled d+1 edges after the strobe edge.
    task automatic engine(input int d, output logic [2:0] afp,
                          output logic [2:0] arr);
        repeat (d) @(negedge clk);
        @(negedge clk) done = 1'b1;
        @(posedge clk);
        #1;
        afp = fp_ack;
        arr = rr_ack;
        @(negedge clk) done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t0, t1, prev;
        bit ackseen;
        logic [2:0] afp, arr, eg;
        logic [8:0] bw [4];
        logic [8:0] chd [3];

        bw  = '{9'h1A0, 9'h0A1, 9'h1A2, 9'h0A3};
        chd = '{CH0, CH1, CH2};

        tbl[0]  = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000};
        tbl[1]  = '{3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000};
        tbl[2]  = '{3'b110, 1'b0, 3'b010, 1'b1, 3'b000, 1'b0, CH1};
        tbl[3]  = '{3'b110, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, CH1};
        tbl[4]  = '{3'b110, 1'b1, 3'b010, 1'b0, 3'b010, 1'b0, CH1};
        tbl[5]  = '{3'b100, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, CH1};
        tbl[6]  = '{3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, CH1};
        tbl[7]  = '{3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, CH2};
        tbl[8]  = '{3'b100, 1'b1, 3'b100, 1'b0, 3'b100, 1'b0, CH2};
        tbl[9]  = '{3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 1'b0, CH2};
        tbl[10] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, CH2};
        tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, CH2};
        tbl[12] = '{3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0, CH0};
        tbl[13] = '{3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, CH0};
        tbl[14] = '{3'b000, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0, CH0};
        tbl[15] = '{3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, CH0};
        tbl[16] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, CH0};

        // Reset state and fixed-priority cycle table
        do_reset();
        #1;
        chk("reset_fp", {fp_grant, fp_en, fp_ack, fp_err, fp_data}, 0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            req  = tbl[i].req;
            done = tbl[i].done;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {fp_grant, fp_en, fp_ack, fp_err, fp_data},
                {tbl[i].g, tbl[i].en, tbl[i].ack, tbl[i].err, tbl[i].d});
        end
        @(negedge clk) done = 1'b0;

        // Round robin, all channels requesting, unlocked
        do_reset();
        @(negedge clk) req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            eg = 3'(1 << (n % 3));
            wait_en(1'b1, "rr_en", t);
            chk($sformatf("rr_grant%0d", n), rr_grant, eg);
            chk($sformatf("rr_data%0d", n), rr_data, chd[n % 3]);
            chk($sformatf("fp_grant%0d", n), fp_grant, 3'b001);
            engine(1, afp, arr);
            chk($sformatf("rr_ack%0d", n), arr, eg);
        end
        req = '0;
        repeat (4) @(posedge clk);

        // Locked burst on ch0 while ch1 waits
        do_reset();
        @(negedge clk);
        lock = 3'b001;
        req  = 3'b011;
        cdata[8:0]  = bw[0];
        cdata[17:9] = 9'h055;
        prev = 0;
        for (int w = 0; w < 4; w++) begin
            wait_en(1'b0, "bu_en", t);
            chk($sformatf("bu_grant%0d", w), fp_grant, 3'b001);
            chk($sformatf("bu_data%0d", w), fp_data, bw[w]);
            if (w > 0)
                chk($sformatf("bu_gap%0d", w), t - prev, 5);
            prev = t;
            engine(2, afp, arr);
            chk($sformatf("bu_ack%0d", w), afp, 3'b001);
            if (w < 3) begin
                cdata[8:0] = bw[w + 1];
            end else begin
                lock = '0;
                req  = 3'b010;
            end
        end
        wait_en(1'b0, "bu_ch1", t);
        chk("bu_ch1", {fp_grant, fp_data}, {3'b010, 9'h055});
        chk("bu_gap_unlock", t - prev, 6);
        engine(1, afp, arr);
        req = '0;
        repeat (4) @(posedge clk);

        // Timeout, re-grant, then wr_done on the expiry cycle
        do_reset();
        @(negedge clk) req = 3'b100;
        wait_en(1'b0, "to_en", t0);
        chk("to_grant", fp_grant, 3'b100);
        ackseen = 1'b0;
        t1 = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (fp_ack != 3'b000) ackseen = 1'b1;
            if (fp_err) begin
                t1 = cyc;
                break;
            end
        end
        chk("to_delay", t1 - t0, 10);
        chk("to_grant0", fp_grant, 3'b000);
        chk("to_noack", 32'(ackseen), 0);
        @(posedge clk);
        #1;
        chk("to_regrant", {fp_grant, fp_en, fp_err}, {3'b100, 1'b1, 1'b0});
        repeat (9) @(posedge clk);
        @(negedge clk) done = 1'b1;
        @(posedge clk);
        #1;
        chk("co_ack", {fp_ack, fp_err}, {3'b100, 1'b0});
        @(negedge clk);
        done = 1'b0;
        req  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("co_idle", {fp_grant, fp_err}, 0);

        // Reset in WAIT, then ch0 first with a stale wr_done
        do_reset();
        @(negedge clk) req = 3'b001;
        wait_en(1'b0, "rs_en", t);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_fp", {fp_grant, fp_en, fp_ack, fp_err, fp_data}, 0);
        chk("rs_rr", {rr_grant, rr_en, rr_ack, rr_err, rr_data}, 0);
        @(negedge clk);
        req  = 3'b101;
        done = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rs_fp_first", {fp_grant, fp_en, fp_ack}, {3'b001, 1'b1, 3'b000});
        chk("rs_rr_first", {rr_grant, rr_en, rr_ack}, {3'b001, 1'b1, 3'b000});
        @(negedge clk) done = 1'b0;
        engine(1, afp, arr);
        chk("rs_ack", afp, 3'b001);
        req = '0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
